muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file. It consumes the two read-port operands and returns a 32-bit result, plus a destination index and write strobe, that drive the register-file write port.
- Multi-cycle with fixed latency. The core controller stalls on `busy` and treats `done` as the register-file write enable.

---
 rtl/muldiv_unit_if.sv | 17 +
 rtl/muldiv_unit.sv | 93 +++++++++
 tb/tb_muldiv_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/result bus between the register file and the RV32M multiply/divide unit
interface muldiv_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [2:0]        op;
  logic [XLEN-1:0]   operand_a;
  logic [XLEN-1:0]   operand_b;
  logic [ADDR_W-1:0] rd_in;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [ADDR_W-1:0] rd_out;
  modport master (output start, op, operand_a, operand_b, rd_in, input busy, done, result, rd_out);
  modport slave  (input start, op, operand_a, operand_b, rd_in, output busy, done, result, rd_out);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 32 radix-2 steps plus a sign-correction cycle
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_ma, r_mb, r_result;
  logic              r_neg, r_fin, r_busy, r_done;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [ADDR_W-1:0] r_rd;
  logic              w_accept, w_step, w_final;
  logic              w_a_sgn, w_b_sgn, w_an, w_bn, w_neg, w_ge;
  logic [XLEN-1:0]   w_ma, w_mb, w_quo, w_rem, w_res;
  logic [XLEN:0]     w_madd, w_trial, w_diff;
  logic [2*XLEN-1:0] w_mstep, w_dstep, w_prod;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_accept = r_state == IDLE && bus.start;
    w_step   = r_state == CALC && !r_fin;
    w_final  = r_state == CALC && r_fin;
    w_next   = w_accept ? CALC : w_final ? DONE : r_state == DONE ? IDLE : r_state;
  end
  // Operand signedness and result sign; a zero divisor keeps the quotient positive so DIV by 0 yields all ones
  always_comb begin
    w_a_sgn = bus.op == 3'b001 || bus.op == 3'b010 || bus.op == 3'b100 || bus.op == 3'b110;
    w_b_sgn = bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110;
    w_an    = w_a_sgn && bus.operand_a[XLEN-1];
    w_bn    = w_b_sgn && bus.operand_b[XLEN-1];
    w_ma    = w_an ? -bus.operand_a : bus.operand_a;
    w_mb    = w_bn ? -bus.operand_b : bus.operand_b;
    w_neg   = bus.op[2] ? (bus.op[1] ? w_an : (w_an ^ w_bn) && bus.operand_b != '0) : w_an ^ w_bn;
  end
  // r_acc holds {hi, lo}: product halves for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_ma} : '0);
    w_mstep = {w_madd, r_acc[XLEN-1:1]};
    w_trial = r_acc[2*XLEN-1:XLEN-1];
    w_ge    = w_trial >= {1'b0, r_mb};
    w_diff  = w_trial - {1'b0, r_mb};
    w_dstep = {w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
    w_prod  = r_neg ? -r_acc : r_acc;
    w_quo   = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem   = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_res   = r_op[2] ? (r_op[1] ? w_rem : w_quo) : (r_op == 3'b000 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_op     <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_acc    <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_accept) begin
        r_op   <= bus.op;
        r_ma   <= w_ma;
        r_mb   <= w_mb;
        r_neg  <= w_neg;
        r_cnt  <= 5'd31;
        r_fin  <= 1'b0;
        r_acc  <= {{XLEN{1'b0}}, bus.op[2] ? w_ma : w_mb};
        r_rd   <= bus.rd_in;
        r_busy <= 1'b1;
      end
      if (w_step) begin
        r_acc <= r_op[2] ? w_dstep : w_mstep;
        r_cnt <= r_cnt - 5'd1;
        r_fin <= r_cnt == 5'd0;
      end
      if (w_final) r_result <= w_res;
      if (r_state == DONE) r_busy <= 1'b0;
    end
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of latency, results and handshake of muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = ~o; bus.operand_a = ~a; bus.operand_b = b + 32'd1; bus.rd_in = ~rd;
    chk({tag, "_busy_after_accept"}, bus.busy, 1);
    wait_done(n);
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_result"}, bus.result, exp);
    chk({tag, "_rd_out"}, bus.rd_out, rd);
    chk({tag, "_busy_in_done"}, bus.busy, 1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_busy_clear"}, bus.busy, 0);
    chk({tag, "_result_hold"}, bus.result, exp);
  endtask
  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0; bus.rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_rd", bus.rd_out, 0);
    @(negedge clk) rst = 1'b0;
    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.operand_a = 32'd7; bus.operand_b = 32'd9; bus.rd_in = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_result", bus.result, 0);
    chk("rst_mid_rd", bus.rd_out, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("rst_mid_no_done", seen, 0);
    run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF);
    run_op("divu", 3'b101, 32'hFFFFFFF9, 32'd2, 5'd12, 32'h7FFFFFFC);
    run_op("remu", 3'b111, 32'hFFFFFFF9, 32'd2, 5'd13, 32'd1);
    run_op("div_by0", 3'b100, 32'd100, 32'd0, 5'd14, 32'hFFFFFFFF);
    run_op("remu_by0", 3'b111, 32'd100, 32'd0, 5'd15, 32'd100);
    run_op("div_neg_by0", 3'b100, 32'hFFFFFFF9, 32'd0, 5'd16, 32'hFFFFFFFF);
    run_op("rem_neg_by0", 3'b110, 32'hFFFFFFF9, 32'd0, 5'd17, 32'hFFFFFFF9);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.operand_a = 32'd3; bus.operand_b = 32'd5; bus.rd_in = 5'd1;
    @(posedge clk); #1;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      bus.op = 3'b001; bus.operand_a = 32'd100 + n; bus.operand_b = 32'd2; bus.rd_in = 5'd7;
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_first_latency", n, 33);
    chk("b2b_first_result", bus.result, 32'd15);
    chk("b2b_first_rd", bus.rd_out, 5'd1);
    bus.op = 3'b000; bus.operand_a = 32'd5; bus.operand_b = 32'd5; bus.rd_in = 5'd3;
    @(posedge clk); #1;
    chk("b2b_idle_gap", bus.busy, 0);
    bus.op = 3'b101; bus.operand_a = 32'd1000; bus.operand_b = 32'd7; bus.rd_in = 5'd9;
    @(posedge clk); #1;
    chk("b2b_second_accept", bus.busy, 1);
    bus.op = 3'b000; bus.operand_a = 32'd0; bus.operand_b = 32'd0; bus.rd_in = 5'd0;
    wait_done(n);
    bus.start = 1'b0;
    chk("b2b_second_latency", n, 33);
    chk("b2b_second_result", bus.result, 32'd142);
    chk("b2b_second_rd", bus.rd_out, 5'd9);
    @(posedge clk); #1;
    chk("b2b_second_busy_clear", bus.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
